// File: rtl/id_ex_stage_if.sv
// ID/EX boundary bundle: decoded ID-stage fields in, registered EX-slot fields
// and hazard status out. The stage uses the slave modport; the decoder/driver uses master.
interface id_ex_stage_if #(parameter int CNT_W = 16);
   logic              RegWrite_i, ALUSrc_i, Branch_i, Extend_i, Jump_i, MemRead_i, MemWrite_i;
   logic [2:0]        ALU_op_i;
   logic [1:0]        RegDst_i, BranchType_i, MemToReg_i;
   logic [31:0]       pc4_i, rs_data_i, rt_data_i, imm_i;
   logic [4:0]        rs_i, rt_i, rd_i;
   logic [5:0]        funct_i;
   logic              flush_i, hold_i;

   logic              ex_RegWrite_o, ex_ALUSrc_o, ex_Branch_o, ex_Extend_o, ex_Jump_o;
   logic              ex_MemRead_o, ex_MemWrite_o;
   logic [2:0]        ex_ALU_op_o;
   logic [1:0]        ex_RegDst_o, ex_BranchType_o, ex_MemToReg_o;
   logic [31:0]       ex_pc4_o, ex_rs_data_o, ex_rt_data_o, ex_imm_o;
   logic [4:0]        ex_rs_o, ex_rt_o, ex_wreg_o;
   logic [5:0]        ex_funct_o;
   logic              ex_valid_o, stall_o;
   logic [CNT_W-1:0]  bubble_cnt_o;

   modport slave (
      input  RegWrite_i, ALUSrc_i, Branch_i, Extend_i, Jump_i, MemRead_i, MemWrite_i,
             ALU_op_i, RegDst_i, BranchType_i, MemToReg_i, pc4_i, rs_data_i, rt_data_i,
             imm_i, rs_i, rt_i, rd_i, funct_i, flush_i, hold_i,
      output ex_RegWrite_o, ex_ALUSrc_o, ex_Branch_o, ex_Extend_o, ex_Jump_o, ex_MemRead_o,
             ex_MemWrite_o, ex_ALU_op_o, ex_RegDst_o, ex_BranchType_o, ex_MemToReg_o,
             ex_pc4_o, ex_rs_data_o, ex_rt_data_o, ex_imm_o, ex_rs_o, ex_rt_o, ex_wreg_o,
             ex_funct_o, ex_valid_o, stall_o, bubble_cnt_o
   );

   modport master (
      output RegWrite_i, ALUSrc_i, Branch_i, Extend_i, Jump_i, MemRead_i, MemWrite_i,
             ALU_op_i, RegDst_i, BranchType_i, MemToReg_i, pc4_i, rs_data_i, rt_data_i,
             imm_i, rs_i, rt_i, rd_i, funct_i, flush_i, hold_i,
      input  ex_RegWrite_o, ex_ALUSrc_o, ex_Branch_o, ex_Extend_o, ex_Jump_o, ex_MemRead_o,
             ex_MemWrite_o, ex_ALU_op_o, ex_RegDst_o, ex_BranchType_o, ex_MemToReg_o,
             ex_pc4_o, ex_rs_data_o, ex_rt_data_o, ex_imm_o, ex_rs_o, ex_rt_o, ex_wreg_o,
             ex_funct_o, ex_valid_o, stall_o, bubble_cnt_o
   );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion,
// flush/hold control and a saturating bubble counter.
module id_ex_stage #(
   parameter int CNT_W = 16
) (
   input  logic           clk_i,
   input  logic           rst_i,
   id_ex_stage_if.slave   bus
);
   typedef struct packed {
      logic       regWrite, aluSrc, branch, extend, jump, memRead, memWrite;
      logic [2:0] aluOp;
      logic [1:0] regDst, branchType, memToReg;
   } ctrl_t;

   typedef struct packed {
      ctrl_t       ctrl;
      logic [31:0] pc4, rsData, rtData, imm;
      logic [4:0]  rs, rt, wreg;
      logic [5:0]  funct;
      logic        valid;
   } slot_t;

   slot_t            idSlot, exQ;
   logic [CNT_W-1:0] bubbleCnt;
   logic [4:0]       wregNext;
   logic             rtUsed, hz;

   always_comb begin
      wregNext = 5'd0;
      case (bus.RegDst_i)
         2'b00:   wregNext = bus.rt_i;
         2'b01:   wregNext = bus.rd_i;
         2'b10:   wregNext = 5'd31;
         default: wregNext = 5'd0;
      endcase
   end

   always_comb begin
      idSlot.ctrl   = '{bus.RegWrite_i, bus.ALUSrc_i, bus.Branch_i, bus.Extend_i, bus.Jump_i,
                        bus.MemRead_i, bus.MemWrite_i, bus.ALU_op_i, bus.RegDst_i,
                        bus.BranchType_i, bus.MemToReg_i};
      idSlot.pc4    = bus.pc4_i;
      idSlot.rsData = bus.rs_data_i;
      idSlot.rtData = bus.rt_data_i;
      idSlot.imm    = bus.imm_i;
      idSlot.rs     = bus.rs_i;
      idSlot.rt     = bus.rt_i;
      idSlot.wreg   = wregNext;
      idSlot.funct  = bus.funct_i;
      idSlot.valid  = 1'b1;
   end

   // rt only matters as a source when it feeds the ALU, store data or a compare
   assign rtUsed = ~bus.ALUSrc_i | bus.MemWrite_i | bus.Branch_i;
   assign hz     = exQ.valid & exQ.ctrl.memRead & (exQ.wreg != 5'd0) &
                   ((exQ.wreg == bus.rs_i) | ((exQ.wreg == bus.rt_i) & rtUsed));
   assign bus.stall_o = hz & ~bus.flush_i & ~bus.hold_i;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i)                       exQ <= '0;
      else if (!bus.hold_i) begin
         if (bus.flush_i || hz)         exQ <= '0;
         else                           exQ <= idSlot;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i)                                         bubbleCnt <= '0;
      else if (!bus.hold_i && !bus.flush_i && hz && !(&bubbleCnt))
                                                          bubbleCnt <= bubbleCnt + 1'b1;
   end

   assign bus.ex_RegWrite_o   = exQ.ctrl.regWrite;
   assign bus.ex_ALUSrc_o     = exQ.ctrl.aluSrc;
   assign bus.ex_Branch_o     = exQ.ctrl.branch;
   assign bus.ex_Extend_o     = exQ.ctrl.extend;
   assign bus.ex_Jump_o       = exQ.ctrl.jump;
   assign bus.ex_MemRead_o    = exQ.ctrl.memRead;
   assign bus.ex_MemWrite_o   = exQ.ctrl.memWrite;
   assign bus.ex_ALU_op_o     = exQ.ctrl.aluOp;
   assign bus.ex_RegDst_o     = exQ.ctrl.regDst;
   assign bus.ex_BranchType_o = exQ.ctrl.branchType;
   assign bus.ex_MemToReg_o   = exQ.ctrl.memToReg;
   assign bus.ex_pc4_o        = exQ.pc4;
   assign bus.ex_rs_data_o    = exQ.rsData;
   assign bus.ex_rt_data_o    = exQ.rtData;
   assign bus.ex_imm_o        = exQ.imm;
   assign bus.ex_rs_o         = exQ.rs;
   assign bus.ex_rt_o         = exQ.rt;
   assign bus.ex_wreg_o       = exQ.wreg;
   assign bus.ex_funct_o      = exQ.funct;
   assign bus.ex_valid_o      = exQ.valid;
   assign bus.bubble_cnt_o    = bubbleCnt;
endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: a reference model predicts each EX slot,
// the prediction is queued at drive time and compared after the clock edge.
module tb_id_ex_stage;
   localparam int CNT_W = 4;
   localparam logic [15:0] ADD  = 16'h8090;
   localparam logic [15:0] LW   = 16'hC401;
   localparam logic [15:0] ADDI = 16'hC000;
   localparam logic [15:0] SW   = 16'h4200;
   localparam logic [15:0] JAL  = 16'h8823;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   id_ex_stage_if #(.CNT_W(CNT_W)) bus();
   id_ex_stage #(.CNT_W(CNT_W)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

   typedef struct packed {
      logic [15:0]      ctrl;
      logic [4:0]       wreg;
      logic             valid;
      logic [CNT_W-1:0] cnt;
      logic [31:0]      pc4, rsD, rtD, imm;
      logic [4:0]       rs, rt;
      logic [5:0]       funct;
   } exp_t;

   exp_t        m;
   exp_t        q[$];
   int          nChecks = 0;
   int          nFails  = 0;
   logic [15:0] curCtrl;
   logic [4:0]  curRs, curRt, curRd;
   logic [5:0]  curFunct;
   logic [31:0] curPc4, curRsD, curRtD, curImm;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nChecks++;
      if (got !== exp) begin
         nFails++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [15:0] dutCtrl();
      return {bus.ex_RegWrite_o, bus.ex_ALUSrc_o, bus.ex_Branch_o, bus.ex_Extend_o,
              bus.ex_Jump_o, bus.ex_MemRead_o, bus.ex_MemWrite_o, bus.ex_ALU_op_o,
              bus.ex_RegDst_o, bus.ex_BranchType_o, bus.ex_MemToReg_o};
   endfunction

   task automatic chkSlot(input exp_t e);
      chk("ctrl",  32'(dutCtrl()), 32'(e.ctrl));
      chk("wreg",  32'(bus.ex_wreg_o), 32'(e.wreg));
      chk("valid", 32'(bus.ex_valid_o), 32'(e.valid));
      chk("bcnt",  32'(bus.bubble_cnt_o), 32'(e.cnt));
      chk("pc4",   bus.ex_pc4_o, e.pc4);
      chk("rsD",   bus.ex_rs_data_o, e.rsD);
      chk("rtD",   bus.ex_rt_data_o, e.rtD);
      chk("imm",   bus.ex_imm_o, e.imm);
      chk("regs",  32'({bus.ex_rs_o, bus.ex_rt_o, bus.ex_funct_o}), 32'({e.rs, e.rt, e.funct}));
      chk("noWrInv", 32'(!bus.ex_valid_o && (bus.ex_RegWrite_o || bus.ex_MemWrite_o)), 32'd0);
   endtask

   task automatic setId(input logic [15:0] c, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd);
      curCtrl = c; curRs = rs; curRt = rt; curRd = rd;
      curFunct = 6'($urandom); curPc4 = $urandom; curRsD = $urandom;
      curRtD = $urandom; curImm = $urandom;
      {bus.RegWrite_i, bus.ALUSrc_i, bus.Branch_i, bus.Extend_i, bus.Jump_i, bus.MemRead_i,
       bus.MemWrite_i, bus.ALU_op_i, bus.RegDst_i, bus.BranchType_i, bus.MemToReg_i} = c;
      bus.rs_i = rs; bus.rt_i = rt; bus.rd_i = rd; bus.funct_i = curFunct;
      bus.pc4_i = curPc4; bus.rs_data_i = curRsD; bus.rt_data_i = curRtD; bus.imm_i = curImm;
   endtask

   // Called at a falling edge with ID inputs already set; ends at the next falling edge.
   task automatic cycle(input logic fl, input logic hd);
      exp_t nxt, e;
      logic rtUsed, hz;
      bus.flush_i = fl; bus.hold_i = hd;
      #1;
      rtUsed = ~curCtrl[14] | curCtrl[9] | curCtrl[13];
      hz = m.valid && m.ctrl[10] && (m.wreg != 5'd0) &&
           ((m.wreg == curRs) || ((m.wreg == curRt) && rtUsed));
      chk("stall", 32'(bus.stall_o), 32'(hz && !fl && !hd));
      nxt = m;
      if (!hd) begin
         if (fl || hz) begin
            nxt = '0;
            nxt.cnt = m.cnt;
            if (!fl && m.cnt != {CNT_W{1'b1}}) nxt.cnt = m.cnt + 1'b1;
         end else begin
            nxt.ctrl = curCtrl; nxt.valid = 1'b1; nxt.cnt = m.cnt;
            case (curCtrl[5:4])
               2'b00:   nxt.wreg = curRt;
               2'b01:   nxt.wreg = curRd;
               2'b10:   nxt.wreg = 5'd31;
               default: nxt.wreg = 5'd0;
            endcase
            nxt.pc4 = curPc4; nxt.rsD = curRsD; nxt.rtD = curRtD; nxt.imm = curImm;
            nxt.rs = curRs; nxt.rt = curRt; nxt.funct = curFunct;
         end
      end
      q.push_back(nxt);
      m = nxt;
      @(posedge clk);
      #1;
      if (q.size() == 0) chk("sbEmpty", 32'd0, 32'd1);
      else begin
         e = q.pop_front();
         chkSlot(e);
      end
      @(negedge clk);
   endtask

   initial begin
      m = '0;
      bus.flush_i = 1'b0; bus.hold_i = 1'b0;
      setId(ADD, 5'd1, 5'd2, 5'd3);
      #2;
      chkSlot(m);
      chk("stallRst", 32'(bus.stall_o), 32'd0);

      @(negedge clk); rst = 1'b1;
      // add $3 then lw $2 followed by a dependent add
      setId(ADD, 5'd1, 5'd2, 5'd3); cycle(1'b0, 1'b0);
      chk("addWreg", 32'(bus.ex_wreg_o), 32'd3);
      setId(LW, 5'd4, 5'd2, 5'd0);  cycle(1'b0, 1'b0);
      setId(ADD, 5'd2, 5'd6, 5'd7); cycle(1'b0, 1'b0);
      chk("bubbleCtrl", 32'(dutCtrl()), 32'd0);
      chk("bubbleCnt1", 32'(bus.bubble_cnt_o), 32'd1);
      cycle(1'b0, 1'b0);
      // addi reading rt via immediate path: no hazard; sw uses rt as store data
      setId(LW, 5'd4, 5'd2, 5'd0);   cycle(1'b0, 1'b0);
      setId(ADDI, 5'd5, 5'd2, 5'd0); cycle(1'b0, 1'b0);
      setId(LW, 5'd4, 5'd2, 5'd0);   cycle(1'b0, 1'b0);
      setId(SW, 5'd5, 5'd2, 5'd0);   cycle(1'b0, 1'b0);
      cycle(1'b0, 1'b0);
      // flush overrides the hazard; hold freezes everything
      setId(LW, 5'd4, 5'd2, 5'd0);  cycle(1'b0, 1'b0);
      setId(ADD, 5'd2, 5'd6, 5'd7); cycle(1'b1, 1'b0);
      setId(LW, 5'd4, 5'd2, 5'd0);  cycle(1'b0, 1'b0);
      setId(ADD, 5'd2, 5'd6, 5'd7); cycle(1'b0, 1'b1);
      cycle(1'b1, 1'b1);
      cycle(1'b0, 1'b0);
      // jal writes $31
      setId(JAL, 5'd0, 5'd0, 5'd9); cycle(1'b0, 1'b0);
      chk("jalWreg", 32'(bus.ex_wreg_o), 32'd31);
      chk("jalM2R", 32'(bus.ex_MemToReg_o), 32'd3);
      // drive the counter to saturation and past it
      for (int i = 0; i < 18; i++) begin
         setId(LW, 5'd4, 5'd2, 5'd0);  cycle(1'b0, 1'b0);
         setId(ADD, 5'd6, 5'd2, 5'd7); cycle(1'b0, 1'b0);
      end
      chk("bcntSat", 32'(bus.bubble_cnt_o), 32'(2**CNT_W - 1));
      // random mix with small register range so hazards are frequent
      for (int i = 0; i < 60; i++) begin
         setId(16'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               5'($urandom_range(0, 3)));
         cycle(($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
      end
      // asynchronous reset in the middle of a stall
      setId(LW, 5'd4, 5'd2, 5'd0);  cycle(1'b0, 1'b0);
      setId(ADD, 5'd2, 5'd6, 5'd7);
      #1;
      chk("preRstStall", 32'(bus.stall_o), 32'd1);
      rst = 1'b0;
      #1;
      m = '0;
      chkSlot(m);
      chk("rstStall", 32'(bus.stall_o), 32'd0);
      rst = 1'b1;
      cycle(1'b0, 1'b0);
      chk("postRstLoad", 32'(bus.ex_valid_o), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end
endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the bubble counter.
REQ-002 SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_i, input, 1, reset; asynchronous, active-low.
REQ-004 SHALL have ports RegWrite_i, ALUSrc_i, Branch_i, Extend_i, Jump_i, MemRead_i, MemWrite_i, input, 1 each, decoder controls for the instruction in ID.
REQ-005 SHALL have ports ALU_op_i [2:0], RegDst_i [1:0], BranchType_i [1:0], MemToReg_i [1:0], input, decoder multi-bit controls.
REQ-006 SHALL have ports pc4_i, rs_data_i, rt_data_i, imm_i, input, 32 each, ID-stage PC+4, register file read data, extended immediate.
REQ-007 SHALL have ports rs_i, rt_i, rd_i, input, 5 each, ID source and destination register numbers; funct_i, input, 6.
REQ-008 SHALL have ports flush_i, input, 1, branch/jump redirect kill; hold_i, input, 1, external freeze of the whole pipe.
REQ-009 SHALL have registered outputs ex_*_o mirroring every control input in REQ-004/005 plus ex_pc4_o, ex_rs_data_o, ex_rt_data_o, ex_imm_o (32), ex_rs_o, ex_rt_o (5), ex_funct_o (6).
REQ-010 SHALL have ex_wreg_o, output, 5, resolved write register; ex_valid_o, output, 1, EX slot holds a real instruction.
REQ-011 SHALL have stall_o, output, 1, combinational, tells PC and IF/ID to hold.
REQ-012 SHALL have bubble_cnt_o, output, CNT_W, count of bubbles inserted.

Function
REQ-013 SHALL resolve write register: RegDst 00->rt_i, 01->rd_i, 10->31 (jal), 11->0.
REQ-014 SHALL detect load-use hazard: hz = ex_valid_o & ex_MemRead_o & (ex_wreg_o != 0) & ((ex_wreg_o == rs_i) | (ex_wreg_o == rt_i & (~ALUSrc_i | MemWrite_i | Branch_i))).
REQ-015 SHALL drive stall_o = hz & ~flush_i & ~hold_i.
REQ-016 SHALL apply per-edge priority: hold_i > flush_i > hz > normal load.
REQ-017 hold_i=1: all registers, counter included, keep value.
REQ-018 flush_i=1 (no hold): load bubble: all control outputs 0, ex_valid_o=0, ex_wreg_o=0; data fields don't-care but loaded with 0; counter unchanged.
REQ-019 hz=1 (no hold, no flush): load bubble as REQ-018 and increment bubble_cnt_o.
REQ-020 otherwise: load all ID inputs, ex_wreg_o per REQ-013, ex_valid_o=1.
REQ-021 SHALL give latency of exactly one clock from ID input to ex_* output.
REQ-022 SHALL saturate bubble_cnt_o at all-ones; no wrap.
REQ-023 SHALL never assert ex_RegWrite_o or ex_MemWrite_o while ex_valid_o=0.
REQ-024 SHALL insert at most one bubble per load: after a bubble ex_MemRead_o=0, so hz deasserts next cycle.

Reset
REQ-025 rst_i low SHALL immediately clear every output register to 0, bubble_cnt_o included, ex_valid_o=0, regardless of clock.
REQ-026 Reset mid-stall SHALL drop stall_o to 0 combinationally (ex_valid_o=0).
REQ-027 First edge after rst_i rises SHALL perform a normal load per REQ-016.

Verification
REQ-028 add $3 in ID (RegDst 01, rd=3, RegWrite 1) -> next edge ex_wreg_o=3, ex_RegWrite_o=1, ex_valid_o=1, stall_o=0.
REQ-029 lw $2 in EX (ex_wreg_o=2), ID add rs=2 -> stall_o=1, next edge all ex controls 0, bubble_cnt_o=1; following cycle stall_o=0, add loads.
REQ-030 lw $2 in EX, ID addi rs=5 rt=2 (ALUSrc 1) -> stall_o=0, no bubble; same with sw rt=2 -> stall_o=1.
REQ-031 hz=1 and flush_i=1 together -> stall_o=0, bubble loaded, counter unchanged; hold_i=1 -> outputs frozen, stall_o=0.
REQ-032 jal (RegDst 10, MemToReg 11) -> ex_wreg_o=31, ex_MemToReg_o=2'b11; counter preset at 16'hFFFF plus bubble -> stays 16'hFFFF.
REQ-033 rst_i low between edges during a stall -> outputs 0 at once, stall_o=0, bubble_cnt_o=0.
